// File: rtl/piso8_serializer.sv
// WIDTH-bit parallel-in/serial-out transmitter with per-frame MSB/LSB order.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso8_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Pin,
  input  logic             ld,
  input  logic             dir,
  output logic             rdy,
  output logic             So,
  output logic             sv,
  output logic             done
);
  localparam int CW = $clog2(WIDTH+1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PAR = 2'd3} state_t;
  logic par_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dreg;
  logic             last;

  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      dreg  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (ld) begin
          shreg <= Pin;
          dreg  <= dir;
          cnt   <= '0;
`ifdef PISO_PARITY_EN
          par_q <= ^Pin;
`endif
        end
        SHIFT: begin
          // shift toward whichever end feeds So, zero filled
          shreg <= dreg ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    sv        = 1'b0;
    So        = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (ld) state_nxt = SHIFT;
      end
      SHIFT: begin
        sv = 1'b1;
        So = dreg ? shreg[0] : shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
        if (last) state_nxt = PAR;
`else
        if (last) state_nxt = DONE;
`endif
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        sv        = 1'b1;
        So        = par_q;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
